// File: rtl/pc_branch_predictor.sv
// Fetch PC generation with a direct-mapped BTB and 2-bit saturating counters.
// Lookup is combinational on if_pc; training from MEM lands at the clock edge.
module pc_branch_predictor #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IDX_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_pc
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr;
  logic             ctr_we;
  logic             tgt_we;
  logic             tag_we;
  logic [31:0]      next_pc;

  // Same-cycle lookup of the fetch PC; reads pre-update contents.
  always_comb begin
    lk_idx        = if_pc[IDX_W+1:2];
    lk_tag        = if_pc[31:IDX_W+2];
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    if_pred_taken = lk_hit && ctr_q[lk_idx][1];
    if_pred_pc    = if_pred_taken ? target_q[lk_idx] : (if_pc + 32'd4);
  end

  always_comb begin
    next_pc = if_pred_pc;
    if (redirect) begin
      next_pc = redirect_pc;
    end else if (pc_stall) begin
      next_pc = if_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pc <= RESET_PC;
    end else begin
      if_pc <= next_pc;
    end
  end

  // Training decode: a taken miss allocates with weakly-taken, hits saturate.
  always_comb begin
    upd_idx = upd_pc[IDX_W+1:2];
    upd_tag = upd_pc[31:IDX_W+2];
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr = 2'b10;
    if (upd_hit) begin
      if (upd_taken) begin
        upd_ctr = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : (ctr_q[upd_idx] + 2'd1);
      end else begin
        upd_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : (ctr_q[upd_idx] - 2'd1);
      end
    end
    ctr_we = upd_valid && (upd_hit || upd_taken);
    tgt_we = upd_valid && upd_taken;
    tag_we = upd_valid && upd_taken && !upd_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (tgt_we) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid_q gates every use.
  always_ff @(posedge clk) begin
    if (ctr_we) begin
      ctr_q[upd_idx] <= upd_ctr;
    end
    if (tgt_we) begin
      target_q[upd_idx] <= upd_target;
    end
    if (tag_we) begin
      tag_q[upd_idx] <= upd_tag;
    end
  end

endmodule

// File: tb/tb_pc_branch_predictor.sv
// Self-checking bench for pc_branch_predictor: vector table through a scoreboard
// queue, plus hand sequences for same-cycle collision and asynchronous reset.
module tb_pc_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_stall, redirect, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] if_pc, if_pred_pc;
  logic        if_pred_taken;

  pc_branch_predictor #(.RESET_PC(32'h0), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_pred_pc(if_pred_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] epc;
    logic        ept;
    logic [31:0] eppc;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ppc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic add(input logic st, input logic rd, input logic [31:0] rp,
                     input logic uv, input logic [31:0] up, input logic ut,
                     input logic [31:0] ug, input logic [31:0] ep,
                     input logic et, input logic [31:0] epp);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rp; v.uv = uv; v.upc = up;
    v.ut = ut; v.utgt = ug; v.epc = ep; v.ept = et; v.eppc = epp;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    pc_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard empty at t=%0t", $time);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d if_pc", e.id), if_pc, e.pc);
      chk($sformatf("v%0d pred_taken", e.id), 32'(if_pred_taken), 32'(e.pt));
      chk($sformatf("v%0d pred_pc", e.id), if_pred_pc, e.ppc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    drive_idle();
    //  stall rd rpc            uv upc           ut utgt           epc            pt eppc
    add(0, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'h4,         0, 32'h8);
    add(0, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'h8,         0, 32'hC);
    add(0, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'hC,         0, 32'h10);
    add(0, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'h10,        0, 32'h14);
    add(1, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'h10,        0, 32'h14);
    add(1, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'h10,        0, 32'h14);
    add(1, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'h10,        0, 32'h14);
    add(1, 1, 32'h200,        0, 32'h0,        0, 32'h0,         32'h200,       0, 32'h204);
    add(0, 0, 32'h0,          1, 32'h40,       1, 32'h100,       32'h204,       0, 32'h208);
    add(0, 1, 32'h40,         0, 32'h0,        0, 32'h0,         32'h40,        1, 32'h100);
    add(0, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'h100,       0, 32'h104);
    add(0, 1, 32'h40,         1, 32'h40,       0, 32'hDEAD_0000, 32'h40,        0, 32'h44);
    add(1, 0, 32'h0,          1, 32'h40,       0, 32'hDEAD_0000, 32'h40,        0, 32'h44);
    add(1, 0, 32'h0,          1, 32'h40,       0, 32'hDEAD_0000, 32'h40,        0, 32'h44);
    add(1, 0, 32'h0,          1, 32'h40,       1, 32'h100,       32'h40,        0, 32'h44);
    add(1, 0, 32'h0,          1, 32'h40,       1, 32'h100,       32'h40,        1, 32'h100);
    add(1, 0, 32'h0,          1, 32'h40,       1, 32'h180,       32'h40,        1, 32'h180);
    add(1, 0, 32'h0,          1, 32'h40,       1, 32'h180,       32'h40,        1, 32'h180);
    add(1, 0, 32'h0,          1, 32'h40,       0, 32'hDEAD_0000, 32'h40,        1, 32'h180);
    add(1, 0, 32'h0,          1, 32'h40,       0, 32'hDEAD_0000, 32'h40,        0, 32'h44);
    add(1, 0, 32'h0,          1, 32'h40,       1, 32'h100,       32'h40,        1, 32'h100);
    add(1, 0, 32'h0,          1, 32'h80,       1, 32'h300,       32'h40,        0, 32'h44);
    add(0, 1, 32'h80,         0, 32'h0,        0, 32'h0,         32'h80,        1, 32'h300);
    add(0, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'h300,       0, 32'h304);
    add(1, 0, 32'h0,          1, 32'h300,      0, 32'h500,       32'h300,       0, 32'h304);
    add(0, 1, 32'hFFFF_FFFC,  0, 32'h0,        0, 32'h0,         32'hFFFF_FFFC, 0, 32'h0);
    add(0, 0, 32'h0,          0, 32'h0,        0, 32'h0,         32'h0,         0, 32'h4);

    repeat (2) @(negedge clk);
    chk("reset if_pc", if_pc, 32'h0);
    chk("reset pred_taken", 32'(if_pred_taken), 32'h0);
    chk("reset pred_pc", if_pred_pc, 32'h4);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      pc_stall = vecs[i].stall; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
      upd_target = vecs[i].utgt;
      e.id = i; e.pc = vecs[i].epc; e.pt = vecs[i].ept; e.ppc = vecs[i].eppc;
      sb.push_back(e);
      @(negedge clk);
      score();
    end

    // Same-cycle update and lookup of 0x80: old prediction until the edge.
    drive_idle();
    redirect = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    chk("coll pre pc", if_pc, 32'h80);
    chk("coll pre taken", 32'(if_pred_taken), 32'h1);
    drive_idle();
    pc_stall = 1'b1; upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b0;
    #1;
    chk("coll same-cycle taken", 32'(if_pred_taken), 32'h1);
    chk("coll same-cycle pred_pc", if_pred_pc, 32'h300);
    @(negedge clk);
    chk("coll after taken", 32'(if_pred_taken), 32'h0);
    chk("coll after pred_pc", if_pred_pc, 32'h84);

    // Asynchronous reset mid-run clears PC at once and discards training.
    drive_idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst if_pc", if_pc, 32'h0);
    chk("async rst pred_pc", if_pred_pc, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    chk("post rst 0x40 taken", 32'(if_pred_taken), 32'h0);
    chk("post rst 0x40 pred_pc", if_pred_pc, 32'h44);
    redirect_pc = 32'h80;
    @(negedge clk);
    chk("post rst 0x80 pred_pc", if_pred_pc, 32'h84);
    drive_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
